mem_stage: RTL and testbench

- MEM stage of the five-stage MIPS pipeline. Sits between the EX/MEM register outputs and the WB stage.
- Holds the word-addressed data memory and performs lw/sw.
- Resolves the branch decision (PCSrc) and drives the MEM/WB pipeline register.
- WB consumes the registered read data, ALU result, destination register, RegWrite and MemtoReg produced here.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/data_memory.sv | 26 ++
 rtl/mem_stage.sv | 91 +++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, opcodes and MEM/WB record for the MIPS pipeline
package pipeline_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;

    typedef struct packed {
        logic [WORD_W-1:0]     read_data;
        logic [WORD_W-1:0]     alu_result;
        logic [REG_ADDR_W-1:0] dest_reg;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  misalign;
    } mem_wb_t;

    // Only the byte offset matters for word alignment.
    function automatic logic is_misaligned(input logic [1:0] byte_offset, input logic access);
        return access && (byte_offset != 2'b00);
    endfunction

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed data memory, synchronous write, asynchronous read
module data_memory
    import pipeline_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read sees pre-edge contents, so a same-cycle write is not forwarded.
    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: data memory access, branch decision, MEM/WB register
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [WORD_W-1:0]     ex_alu_result,
    input  logic [WORD_W-1:0]     ex_write_data,
    input  logic [REG_ADDR_W-1:0] ex_dest_reg,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_branch,
    input  logic                  ex_zero,
    input  logic [WORD_W-1:0]     ex_branch_target,
    output logic [WORD_W-1:0]     wb_read_data,
    output logic [WORD_W-1:0]     wb_alu_result,
    output logic [REG_ADDR_W-1:0] wb_dest_reg,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic                  pc_src,
    output logic [WORD_W-1:0]     branch_target,
    output logic                  misalign
);

    logic                 mis_access;
    logic                 mem_we;
    logic [WORD_W-1:0]    mem_rdata;
    logic [ADDR_BITS-1:0] word_index;
    mem_wb_t              mem_wb_q;
    mem_wb_t              mem_wb_d;

    assign word_index = ex_alu_result[ADDR_BITS+1:2];
    assign mis_access = is_misaligned(ex_alu_result[1:0], ex_mem_read | ex_mem_write);
    // rst_n gates the write so a reset landing on an edge cannot corrupt a word.
    assign mem_we     = ex_mem_write & ~stall & ~mis_access & rst_n;

    data_memory #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_data_memory (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_index),
        .wdata (ex_write_data),
        .rdata (mem_rdata)
    );

    assign pc_src        = ex_branch & ex_zero;
    assign branch_target = ex_branch_target;

    always_comb begin
        mem_wb_d = mem_wb_q;
        if (flush || !stall) begin
            mem_wb_d.read_data  = ex_mem_read ? mem_rdata : '0;
            mem_wb_d.alu_result = ex_alu_result;
            mem_wb_d.dest_reg   = ex_dest_reg;
        end
        if (flush) begin
            mem_wb_d.reg_write  = 1'b0;
            mem_wb_d.mem_to_reg = 1'b0;
            mem_wb_d.misalign   = 1'b0;
        end else if (!stall) begin
            mem_wb_d.reg_write  = ex_reg_write & ~mis_access;
            mem_wb_d.mem_to_reg = ex_mem_to_reg;
            mem_wb_d.misalign   = mis_access;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    assign wb_read_data  = mem_wb_q.read_data;
    assign wb_alu_result = mem_wb_q.alu_result;
    assign wb_dest_reg   = mem_wb_q.dest_reg;
    assign wb_reg_write  = mem_wb_q.reg_write;
    assign wb_mem_to_reg = mem_wb_q.mem_to_reg;
    assign misalign      = mem_wb_q.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import pipeline_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  stall;
    logic                  flush;
    logic [WORD_W-1:0]     ex_alu_result;
    logic [WORD_W-1:0]     ex_write_data;
    logic [REG_ADDR_W-1:0] ex_dest_reg;
    logic                  ex_reg_write;
    logic                  ex_mem_to_reg;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_branch;
    logic                  ex_zero;
    logic [WORD_W-1:0]     ex_branch_target;
    logic [WORD_W-1:0]     wb_read_data;
    logic [WORD_W-1:0]     wb_alu_result;
    logic [REG_ADDR_W-1:0] wb_dest_reg;
    logic                  wb_reg_write;
    logic                  wb_mem_to_reg;
    logic                  pc_src;
    logic [WORD_W-1:0]     branch_target;
    logic                  misalign;

    int tests;
    int fails;

    mem_stage #(.DEPTH(256), .ADDR_BITS(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush            (flush),
        .ex_alu_result    (ex_alu_result),
        .ex_write_data    (ex_write_data),
        .ex_dest_reg      (ex_dest_reg),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_branch        (ex_branch),
        .ex_zero          (ex_zero),
        .ex_branch_target (ex_branch_target),
        .wb_read_data     (wb_read_data),
        .wb_alu_result    (wb_alu_result),
        .wb_dest_reg      (wb_dest_reg),
        .wb_reg_write     (wb_reg_write),
        .wb_mem_to_reg    (wb_mem_to_reg),
        .pc_src           (pc_src),
        .branch_target    (branch_target),
        .misalign         (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_alu_result = '0; ex_write_data = '0; ex_dest_reg = '0;
        ex_reg_write = 0; ex_mem_to_reg = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_branch = 0; ex_zero = 0; ex_branch_target = '0;
    endtask

    task automatic drive_sw(input logic [31:0] addr, input logic [31:0] data);
        drive_idle();
        ex_alu_result = addr; ex_write_data = data; ex_mem_write = 1;
    endtask

    task automatic drive_lw(input logic [31:0] addr, input logic [4:0] dest);
        drive_idle();
        ex_alu_result = addr; ex_dest_reg = dest;
        ex_mem_read = 1; ex_reg_write = 1; ex_mem_to_reg = 1;
    endtask

    task automatic drive_rtype(input logic [31:0] res, input logic [4:0] dest);
        drive_idle();
        ex_alu_result = res; ex_dest_reg = dest; ex_reg_write = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; stall = 0; flush = 0;
        drive_rtype(32'hFFFF_FFFF, 5'd31);
        ex_mem_to_reg = 1;
        step(); step();
        tests++; if (wb_alu_result !== 32'h0) begin fails++; $display("FAIL reset_alu: got %h expected %h", wb_alu_result, 32'h0); end
        tests++; if (wb_read_data !== 32'h0) begin fails++; $display("FAIL reset_rd: got %h expected %h", wb_read_data, 32'h0); end
        tests++; if (wb_dest_reg !== 5'd0) begin fails++; $display("FAIL reset_dest: got %0d expected 0", wb_dest_reg); end
        tests++; if ({wb_reg_write, wb_mem_to_reg, misalign} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b expected 000", {wb_reg_write, wb_mem_to_reg, misalign}); end
        #3 rst_n = 1;
        drive_idle();
        step();
    endtask

    task automatic test_store_load();
        drive_sw(32'h0000_0010, 32'h8C12_3456);
        step();
        drive_lw(32'h0000_0010, 5'd8);
        step();
        tests++; if (wb_read_data !== 32'h8C12_3456) begin fails++; $display("FAIL store_load_rd: got %h expected %h", wb_read_data, 32'h8C12_3456); end
        tests++; if (wb_dest_reg !== 5'd8) begin fails++; $display("FAIL store_load_dest: got %0d expected 8", wb_dest_reg); end
        tests++; if ({wb_reg_write, wb_mem_to_reg, misalign} !== 3'b110) begin fails++; $display("FAIL store_load_ctrl: got %b expected 110", {wb_reg_write, wb_mem_to_reg, misalign}); end
    endtask

    task automatic test_rtype();
        drive_rtype(32'h0023_00AA, 5'd3);
        step();
        tests++; if (wb_alu_result !== 32'h0023_00AA) begin fails++; $display("FAIL rtype_alu: got %h expected %h", wb_alu_result, 32'h0023_00AA); end
        tests++; if (wb_read_data !== 32'h0) begin fails++; $display("FAIL rtype_rd: got %h expected %h", wb_read_data, 32'h0); end
        tests++; if ({wb_reg_write, wb_mem_to_reg} !== 2'b10) begin fails++; $display("FAIL rtype_ctrl: got %b expected 10", {wb_reg_write, wb_mem_to_reg}); end
        tests++; if (wb_dest_reg !== 5'd3) begin fails++; $display("FAIL rtype_dest: got %0d expected 3", wb_dest_reg); end
    endtask

    task automatic test_branch();
        drive_idle();
        ex_branch = 1; ex_zero = 1; ex_branch_target = 32'h0000_0040;
        stall = 1; flush = 1;
        #1;
        tests++; if (pc_src !== 1'b1) begin fails++; $display("FAIL branch_taken: got %b expected 1", pc_src); end
        tests++; if (branch_target !== 32'h0000_0040) begin fails++; $display("FAIL branch_target: got %h expected %h", branch_target, 32'h0000_0040); end
        ex_zero = 0;
        #1;
        tests++; if (pc_src !== 1'b0) begin fails++; $display("FAIL branch_not_zero: got %b expected 0", pc_src); end
        ex_branch = 0; ex_zero = 1;
        #1;
        tests++; if (pc_src !== 1'b0) begin fails++; $display("FAIL branch_no_beq: got %b expected 0", pc_src); end
        stall = 0; flush = 0;
        drive_idle();
        step();
    endtask

    task automatic test_stall_flush();
        drive_sw(32'h0000_0020, 32'h1111_2222);
        step();
        drive_rtype(32'h0000_0055, 5'd7);
        step();
        drive_sw(32'h0000_0020, 32'hDEAD_BEEF);
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++; if (wb_alu_result !== 32'h0000_0055 || wb_dest_reg !== 5'd7 || wb_reg_write !== 1'b1) begin
                fails++; $display("FAIL stall_hold[%0d]: got alu=%h dest=%0d rw=%b expected alu=00000055 dest=7 rw=1", i, wb_alu_result, wb_dest_reg, wb_reg_write);
            end
        end
        stall = 0;
        drive_lw(32'h0000_0020, 5'd9);
        step();
        tests++; if (wb_read_data !== 32'h1111_2222) begin fails++; $display("FAIL stall_no_write: got %h expected %h", wb_read_data, 32'h1111_2222); end
        drive_rtype(32'h0000_0077, 5'd4);
        flush = 1;
        step();
        tests++; if ({wb_reg_write, wb_mem_to_reg} !== 2'b00) begin fails++; $display("FAIL flush_ctrl: got %b expected 00", {wb_reg_write, wb_mem_to_reg}); end
        tests++; if (wb_alu_result !== 32'h0000_0077 || wb_dest_reg !== 5'd4) begin fails++; $display("FAIL flush_data: got alu=%h dest=%0d expected alu=00000077 dest=4", wb_alu_result, wb_dest_reg); end
        drive_rtype(32'h0000_0088, 5'd5);
        stall = 1;
        step();
        tests++; if (wb_reg_write !== 1'b0 || wb_alu_result !== 32'h0000_0088) begin fails++; $display("FAIL flush_beats_stall: got rw=%b alu=%h expected rw=0 alu=00000088", wb_reg_write, wb_alu_result); end
        stall = 0; flush = 0;
    endtask

    task automatic test_misalign();
        drive_sw(32'h0000_0012, 32'hFFFF_FFFF);
        step();
        tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL misalign_sw: got %b expected 1", misalign); end
        drive_lw(32'h0000_0010, 5'd2);
        step();
        tests++; if (wb_read_data !== 32'h8C12_3456 || misalign !== 1'b0) begin fails++; $display("FAIL misalign_sw_dropped: got rd=%h mis=%b expected rd=8c123456 mis=0", wb_read_data, misalign); end
        drive_lw(32'h0000_0013, 5'd5);
        step();
        tests++; if (misalign !== 1'b1 || wb_reg_write !== 1'b0) begin fails++; $display("FAIL misalign_lw: got mis=%b rw=%b expected mis=1 rw=0", misalign, wb_reg_write); end
        tests++; if (wb_read_data !== 32'h8C12_3456) begin fails++; $display("FAIL misalign_lw_rd: got %h expected %h", wb_read_data, 32'h8C12_3456); end
        drive_rtype(32'h0000_0013, 5'd6);
        step();
        tests++; if (misalign !== 1'b0 || wb_reg_write !== 1'b1) begin fails++; $display("FAIL misalign_rtype: got mis=%b rw=%b expected mis=0 rw=1", misalign, wb_reg_write); end
    endtask

    task automatic test_wrap_and_old_read();
        drive_sw(32'h0000_0404, 32'h0000_A5A5);
        step();
        drive_lw(32'h0000_0004, 5'd1);
        step();
        tests++; if (wb_read_data !== 32'h0000_A5A5) begin fails++; $display("FAIL wrap_rd: got %h expected %h", wb_read_data, 32'h0000_A5A5); end
        drive_sw(32'h0000_0004, 32'h0000_1234);
        ex_mem_read = 1;
        step();
        tests++; if (wb_read_data !== 32'h0000_A5A5) begin fails++; $display("FAIL same_cycle_old: got %h expected %h", wb_read_data, 32'h0000_A5A5); end
        drive_lw(32'h0000_0004, 5'd1);
        step();
        tests++; if (wb_read_data !== 32'h0000_1234) begin fails++; $display("FAIL same_cycle_new: got %h expected %h", wb_read_data, 32'h0000_1234); end
    endtask

    task automatic test_async_reset();
        drive_sw(32'h0000_0030, 32'h0000_3030);
        step();
        drive_rtype(32'h0000_0099, 5'd6);
        step();
        drive_sw(32'h0000_0030, 32'h0000_CAFE);
        #3 rst_n = 0;
        #1;
        tests++; if (wb_alu_result !== 32'h0 || wb_dest_reg !== 5'd0 || wb_reg_write !== 1'b0) begin fails++; $display("FAIL async_reset_now: got alu=%h dest=%0d rw=%b expected all 0", wb_alu_result, wb_dest_reg, wb_reg_write); end
        step();
        #2 rst_n = 1;
        drive_lw(32'h0000_0030, 5'd10);
        step();
        tests++; if (wb_read_data !== 32'h0000_3030) begin fails++; $display("FAIL async_reset_no_write: got %h expected %h", wb_read_data, 32'h0000_3030); end
        tests++; if (wb_reg_write !== 1'b1 || wb_dest_reg !== 5'd10) begin fails++; $display("FAIL async_reset_resume: got rw=%b dest=%0d expected rw=1 dest=10", wb_reg_write, wb_dest_reg); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        drive_idle();
        test_reset();
        test_store_load();
        test_rtype();
        test_branch();
        test_stall_flush();
        test_misalign();
        test_wrap_and_old_read();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
